// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared GPU constants, block-address type and fill FSM states
// Purpose: widths of the block grid and colour, the {x, y} block address type,
//          and the state encoding of the block fill sequencer.
// Ports:   none (package).
package gpu_pkg;

  localparam int BLK_X_W = 7;                   // 128 block columns
  localparam int BLK_Y_W = 6;                   // 64 block rows
  localparam int COLOR_W = 12;                  // packed 4:4:4 RGB
  localparam int ADDR_W  = BLK_X_W + BLK_Y_W;
  localparam int CNT_W   = ADDR_W + 1;          // holds the full 8192-block count

  typedef logic [ADDR_W-1:0] blk_addr_t;        // {x, y}

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_FILL = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/block_fill_ctrl_if.sv
// rtl/block_fill_ctrl_if.sv - command and frame-memory port-A bundle of the block fill sequencer
// Purpose: groups the fill command handshake, the CPU/abort controls and the
//          port-A address/write/colour outputs with status pulses.
// Modports: master - issues commands, observes port A and status
//           slave  - the fill controller
interface block_fill_ctrl_if import gpu_pkg::*; ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic [BLK_X_W-1:0]  cmd_x0;
  logic [BLK_X_W-1:0]  cmd_x1;
  logic [BLK_Y_W-1:0]  cmd_y0;
  logic [BLK_Y_W-1:0]  cmd_y1;
  logic [COLOR_W-1:0]  cmd_color;
  logic                abort;
  logic                cpu_req;
  logic                mem_sel;
  logic                mem_wren;
  blk_addr_t           mem_address;
  logic [COLOR_W-1:0]  fill_color;
  logic                busy;
  logic                done;
  logic                aborted;
  logic                err;
  logic [CNT_W-1:0]    blk_count;

  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, abort, cpu_req,
    input  cmd_ready, mem_sel, mem_wren, mem_address, fill_color,
           busy, done, aborted, err, blk_count
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, abort, cpu_req,
    output cmd_ready, mem_sel, mem_wren, mem_address, fill_color,
           busy, done, aborted, err, blk_count
  );

endinterface

// File: rtl/block_walker.sv
// rtl/block_walker.sv - rectangle walker producing block addresses, y inner and x outer
// Purpose: holds the rectangle bounds and the current block; steps one block per advance.
// Ports:   clk, clr       clock, synchronous active-high reset
//          load           capture bounds, start at (x0, y0)
//          x0/x1, y0/y1   inclusive rectangle bounds
//          advance        step to the next block
//          addr           current block address {cur_x, cur_y}
//          last           current block is the final one of the rectangle
module block_walker import gpu_pkg::*; (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic               advance,
  input  logic [BLK_X_W-1:0] x0,
  input  logic [BLK_X_W-1:0] x1,
  input  logic [BLK_Y_W-1:0] y0,
  input  logic [BLK_Y_W-1:0] y1,
  output blk_addr_t          addr,
  output logic               last
);

  logic [BLK_X_W-1:0] cur_x;
  logic [BLK_X_W-1:0] lim_x;
  logic [BLK_Y_W-1:0] cur_y;
  logic [BLK_Y_W-1:0] start_y;
  logic [BLK_Y_W-1:0] lim_y;

  always_ff @(posedge clk) begin
    if (clr) begin
      cur_x   <= '0;
      lim_x   <= '0;
      cur_y   <= '0;
      start_y <= '0;
      lim_y   <= '0;
    end else if (load) begin
      cur_x   <= x0;
      lim_x   <= x1;
      cur_y   <= y0;
      start_y <= y0;
      lim_y   <= y1;
    end else if (advance) begin
      if (cur_y == lim_y) begin
        cur_y <= start_y;
        // On the final block x stays at its limit; the controller leaves FILL.
        if (cur_x != lim_x) cur_x <= cur_x + 1'b1;
      end else begin
        cur_y <= cur_y + 1'b1;
      end
    end
  end

  assign last = (cur_x == lim_x) && (cur_y == lim_y);
  assign addr = {cur_x, cur_y};

endmodule

// File: rtl/block_fill_ctrl.sv
// rtl/block_fill_ctrl.sv - fills a rectangle of 8x8 frame-memory blocks with one colour
// Purpose: accepts a fill command, then writes one block per cycle on port A,
//          yielding port A to the CPU whenever cpu_req is high.
// Ports:   clk   single clock
//          clr   synchronous active-high reset, beats every other input
//          bus   block_fill_ctrl_if.slave: command handshake, abort, cpu_req,
//                port-A select/write/address/colour, busy/done/aborted/err, blk_count
module block_fill_ctrl import gpu_pkg::*; (
  input logic               clk,
  input logic               clr,
  block_fill_ctrl_if.slave  bus
);

  fill_state_e        state;
  logic [COLOR_W-1:0] color_q;
  logic [CNT_W-1:0]   count_q;
  logic               err_q;
  logic               aborted_q;
  logic               accept;
  logic               bad_cmd;
  logic               write;
  logic               last;

  assign bus.cmd_ready = (state == FILL_IDLE) && !clr;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bad_cmd       = (bus.cmd_x1 < bus.cmd_x0) || (bus.cmd_y1 < bus.cmd_y0);

  // abort outranks cpu_req, which outranks the write; clr suppresses everything.
  assign write        = (state == FILL_FILL) && !bus.cpu_req && !bus.abort && !clr;
  assign bus.mem_sel  = write;
  assign bus.mem_wren = write;

  block_walker u_walker (
    .clk     (clk),
    .clr     (clr),
    .load    (accept && !bad_cmd),
    .advance (write),
    .x0      (bus.cmd_x0),
    .x1      (bus.cmd_x1),
    .y0      (bus.cmd_y0),
    .y1      (bus.cmd_y1),
    .addr    (bus.mem_address),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= FILL_IDLE;
      color_q   <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      err_q     <= accept && bad_cmd;
      aborted_q <= (state == FILL_FILL) && bus.abort;
      case (state)
        FILL_IDLE: begin
          if (accept && !bad_cmd) begin
            color_q <= bus.cmd_color;
            count_q <= '0;
            state   <= FILL_FILL;
          end
        end
        FILL_FILL: begin
          if (bus.abort) begin
            state <= FILL_IDLE;
          end else if (write) begin
            count_q <= count_q + 1'b1;
            if (last) state <= FILL_DONE;
          end
        end
        FILL_DONE: state <= FILL_IDLE;
        default:   state <= FILL_IDLE;
      endcase
    end
  end

  assign bus.fill_color = color_q;
  assign bus.blk_count  = count_q;
  assign bus.busy       = (state != FILL_IDLE);
  assign bus.done       = (state == FILL_DONE);
  assign bus.err        = err_q;
  assign bus.aborted    = aborted_q;

endmodule
